pkt_wrr_scheduler: RTL and testbench
====================================

Name: pkt_wrr_scheduler

Overview:
- Packet-granular weighted round-robin scheduler that shares the single m_axis datapath between NUM_QUEUES RX queues.
- It issues a one-hot grant to the input mux and holds it until the granted packet's last beat is accepted downstream.
- It emits pkt_fwd for the forwarded-packet counter.
- Control-only block; the data mux stays in the arbiter datapath.

Parameters:
- NUM_QUEUES, 5, number of requesting RX queues (2..8)
- WEIGHT_WIDTH, 4, bits per queue weight; weight = max consecutive packets per turn
- IDX_WIDTH, 3, width of grant_idx; must be >= clog2(NUM_QUEUES)

Ports:
- axi_aclk  in  1  clock
- axi_resetn  in  1  asynchronous active-low reset
- req  in  NUM_QUEUES  bit i = queue i has a packet head pending (its s_axis_tvalid)
- weights  in  NUM_QUEUES*WEIGHT_WIDTH  queue i weight at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]; 0 = queue disabled
- sched_en  in  1  1 = new grants allowed
- pkt_done  in  1  last beat of granted packet accepted (m_axis_tvalid & m_axis_tready & m_axis_tlast)
- grant  out  NUM_QUEUES  one-hot grant to the input mux/tready steering
- grant_valid  out  1  grant is active
- grant_idx  out  IDX_WIDTH  binary index of the granted queue
- pkt_fwd  out  1  one-cycle pulse per completed packet
- err_spurious_done  out  1  sticky flag: pkt_done seen while no grant is active

Behaviour:
- Reset (async on axi_resetn low):
  - grant=0, grant_valid=0, grant_idx=0, pkt_fwd=0, err_spurious_done=0.
  - state=IDLE, last_idx=NUM_QUEUES-1 (so the first search starts at queue 0), credit=0.
- Eligibility: elig[i] = req[i] & (weights[i] != 0).
- Selection, combinational in IDLE:
  - Stay on last_idx if credit != 0 and elig[last_idx].
  - Otherwise choose the first eligible queue scanning last_idx+1, last_idx+2, … modulo NUM_QUEUES; last_idx itself is scanned last.
- State IDLE:
  - If sched_en and |elig: at the clock edge register grant/grant_idx/grant_valid=1, last_idx=sel, and go to XFER.
  - Credit update: on a repeat grant, credit <= credit-1; on a new queue, credit <= weights[sel]-1.
  - Latency from req to grant_valid: 1 cycle.
- State XFER:
  - grant is held stable regardless of req or sched_en changes.
  - On pkt_done: grant=0 and grant_valid=0 next cycle, pkt_fwd=1 for exactly that cycle, return to IDLE.
  - Minimum gap: pkt_done at cycle N gives the next grant_valid at N+2 (one-cycle bubble per packet, accepted).
- Weights are sampled only at selection. A change during XFER takes effect at the next arbitration; the current credit is not recomputed.
- sched_en low in XFER: the current packet completes normally, then no new grant.
- Weight reduced to 0 for the queue that holds credit: that queue is ineligible and the search moves on.
- pkt_done in IDLE: no state change; err_spurious_done set, cleared only by reset.
- Single eligible queue with weight 1: it is re-granted every packet (credit reloads each time).
- Credit arithmetic is WEIGHT_WIDTH-bit unsigned and never underflows. A reload with weight 1 yields 0, which forces a rotation check next time.
- Reset asserted mid-XFER: grant drops asynchronously. Upstream must discard any partial packet; no recovery is attempted.
- Invariant: grant is one-hot or zero, and grant_valid == |grant.

Decomposition:
- Shared package (nf10 arbiter pkg):
  - state encoding IDLE=1'b0, XFER=1'b1
  - default NUM_QUEUES
  - clog2 function for IDX_WIDTH
- Sub-module rr_priority_sel: combinational rotating-priority finder.
  - Inputs: elig vector, start index.
  - Outputs: found, sel_idx, sel_onehot.
  - Reusable by the output queue scheduler.

Test Plan:
- Reset release with req=5'b00001, weights all 1, sched_en=1 -> grant_valid=1 one cycle later, grant=5'b00001, grant_idx=0; pkt_done pulse -> pkt_fwd pulses once, grant=0 next cycle.
- req=5'b11111 held, weights all 1, pkt_done 2 cycles after each grant -> grant_idx sequence 0,1,2,3,4,0; each grant_valid follows its pkt_done by exactly 2 cycles.
- req=5'b00011, weight0=3, weight1=1 -> grant_idx sequence 0,0,0,1,0,0,0,1.
- req=5'b10101, weight2=0 -> queue 2 never granted; sequence 0,4,0,4.
- During XFER on queue 1: drop req[1], deassert sched_en, change weight1 -> grant held until pkt_done; afterwards no grant while sched_en=0; grants resume at index 2 once sched_en=1.
- pkt_done pulsed in IDLE -> err_spurious_done=1 and stays 1, no pkt_fwd; axi_resetn low mid-XFER -> all outputs 0 immediately.

Source files
------------

// File: rtl/pkt_wrr_scheduler_pkg.sv
// Shared definitions for the packet weighted round-robin scheduler.
//   - state_e            : scheduler FSM encoding (IDLE / XFER)
//   - DEFAULT_NUM_QUEUES : default number of requesting RX queues
//   - sched_clog2()      : index width for a given queue count (minimum 1)
package pkt_wrr_scheduler_pkg;

  localparam int DEFAULT_NUM_QUEUES = 5;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  function automatic int sched_clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pkt_wrr_scheduler_sel.sv
// Combinational rotating-priority finder.
// Scans elig starting at start_idx and wrapping modulo N; the first set bit wins.
//   elig       in  N      candidate vector
//   start_idx  in  IDX_W  first index to examine
//   found      out 1      at least one candidate is set
//   sel_idx    out IDX_W  binary index of the winner (0 when none)
//   sel_onehot out N      one-hot winner (0 when none)
module rr_priority_sel
  import pkt_wrr_scheduler_pkg::*;
#(
  parameter int N     = DEFAULT_NUM_QUEUES,
  parameter int IDX_W = sched_clog2(N)
) (
  input  logic [N-1:0]     elig,
  input  logic [IDX_W-1:0] start_idx,
  output logic             found,
  output logic [IDX_W-1:0] sel_idx,
  output logic [N-1:0]     sel_onehot
);

  always_comb begin
    int idx;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    found      = 1'b0;
    sel_idx    = '0;
    sel_onehot = '0;
    idx        = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(start_idx) + k) % N;
      if (!found && elig[idx]) begin
        found           = 1'b1;
        sel_idx         = IDX_W'(idx);
        sel_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_wrr_scheduler.sv
// Packet-granular weighted round-robin scheduler for the shared m_axis path.
// A queue keeps the grant for up to weight consecutive packets while it keeps
// requesting; then the search rotates to the next eligible queue. The grant is
// held from selection until the packet's last beat is accepted.
//   axi_aclk / axi_resetn : clock, asynchronous active-low reset
//   req                   : per-queue packet head pending
//   weights               : packed per-queue weights, 0 disables a queue
//   sched_en              : allow new grants
//   pkt_done              : last beat of the granted packet accepted
//   grant / grant_valid / grant_idx : one-hot grant, active flag, binary index
//   pkt_fwd               : one-cycle pulse per completed packet
//   err_spurious_done     : sticky, pkt_done seen with no active grant
module pkt_wrr_scheduler
  import pkt_wrr_scheduler_pkg::*;
#(
  parameter int NUM_QUEUES   = DEFAULT_NUM_QUEUES,
  parameter int WEIGHT_WIDTH = 4,
  parameter int IDX_WIDTH    = sched_clog2(NUM_QUEUES)
) (
  input  logic                               axi_aclk,
  input  logic                               axi_resetn,
  input  logic [NUM_QUEUES-1:0]              req,
  input  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0] weights,
  input  logic                               sched_en,
  input  logic                               pkt_done,
  output logic [NUM_QUEUES-1:0]              grant,
  output logic                               grant_valid,
  output logic [IDX_WIDTH-1:0]               grant_idx,
  output logic                               pkt_fwd,
  output logic                               err_spurious_done
);

  state_e                  state_q, state_d;
  logic [NUM_QUEUES-1:0]   grant_q, grant_d;
  logic [IDX_WIDTH-1:0]    grant_idx_q, grant_idx_d;
  logic [IDX_WIDTH-1:0]    last_idx_q, last_idx_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
  logic                    pkt_fwd_q, pkt_fwd_d;
  logic                    err_q, err_d;

  logic [WEIGHT_WIDTH-1:0] weight_arr [NUM_QUEUES];
  logic [NUM_QUEUES-1:0]   elig;
  logic [NUM_QUEUES-1:0]   last_onehot;
  logic [IDX_WIDTH-1:0]    start_idx;
  logic                    rr_found;
  logic [IDX_WIDTH-1:0]    rr_idx;
  logic [NUM_QUEUES-1:0]   rr_onehot;
  logic                    stay;
  logic [IDX_WIDTH-1:0]    sel_idx;
  logic [NUM_QUEUES-1:0]   sel_onehot;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      weight_arr[i] = weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      elig[i]       = req[i] & (|weight_arr[i]);
    end
  end

  // Rotation starts just after the last granted queue, so that queue is
  // examined last.
  assign start_idx = (last_idx_q == IDX_WIDTH'(NUM_QUEUES - 1)) ? '0 : last_idx_q + 1'b1;

  rr_priority_sel #(
    .N     (NUM_QUEUES),
    .IDX_W (IDX_WIDTH)
  ) u_rr_sel (
    .elig       (elig),
    .start_idx  (start_idx),
    .found      (rr_found),
    .sel_idx    (rr_idx),
    .sel_onehot (rr_onehot)
  );

  always_comb begin
    last_onehot             = '0;
    last_onehot[last_idx_q] = 1'b1;
  end

  // Remaining credit and still eligible: keep the turn on the same queue.
  assign stay       = (credit_q != '0) && elig[last_idx_q];
  assign sel_idx    = stay ? last_idx_q  : rr_idx;
  assign sel_onehot = stay ? last_onehot : rr_onehot;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    last_idx_d  = last_idx_q;
    credit_d    = credit_q;
    pkt_fwd_d   = 1'b0;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        if (pkt_done) err_d = 1'b1;
        if (sched_en && rr_found) begin
          state_d     = XFER;
          grant_d     = sel_onehot;
          grant_idx_d = sel_idx;
          last_idx_d  = sel_idx;
          // Eligibility guarantees a non-zero weight, and stay guarantees a
          // non-zero credit, so neither subtraction can underflow.
          credit_d    = stay ? credit_q - 1'b1 : weight_arr[sel_idx] - 1'b1;
        end
      end
      XFER: begin
        if (pkt_done) begin
          state_d     = IDLE;
          grant_d     = '0;
          grant_idx_d = '0;
          pkt_fwd_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      last_idx_q  <= IDX_WIDTH'(NUM_QUEUES - 1);
      credit_q    <= '0;
      pkt_fwd_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      last_idx_q  <= last_idx_d;
      credit_q    <= credit_d;
      pkt_fwd_q   <= pkt_fwd_d;
      err_q       <= err_d;
    end
  end

  assign grant             = grant_q;
  assign grant_valid       = |grant_q;
  assign grant_idx         = grant_idx_q;
  assign pkt_fwd           = pkt_fwd_q;
  assign err_spurious_done = err_q;

endmodule

// File: tb/tb_pkt_wrr_scheduler.sv
// Self-checking bench for pkt_wrr_scheduler: a reference model predicts each
// grant and packet-forward event with the clock edge it must appear after; a
// separate monitor pops and compares whenever the DUT shows such an event.
module tb_pkt_wrr_scheduler;

  localparam int N  = 5;
  localparam int W  = 4;
  localparam int IW = 3;

  logic              axi_aclk = 1'b0;
  logic              axi_resetn = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N*W-1:0]    weights = '0;
  logic              sched_en = 1'b0;
  logic              pkt_done = 1'b0;
  logic [N-1:0]      grant;
  logic              grant_valid;
  logic [IW-1:0]     grant_idx;
  logic              pkt_fwd;
  logic              err_spurious_done;

  pkt_wrr_scheduler #(.NUM_QUEUES(N), .WEIGHT_WIDTH(W), .IDX_WIDTH(IW)) dut (
    .axi_aclk          (axi_aclk),
    .axi_resetn        (axi_resetn),
    .req               (req),
    .weights           (weights),
    .sched_en          (sched_en),
    .pkt_done          (pkt_done),
    .grant             (grant),
    .grant_valid       (grant_valid),
    .grant_idx         (grant_idx),
    .pkt_fwd           (pkt_fwd),
    .err_spurious_done (err_spurious_done)
  );

  always #5 axi_aclk = ~axi_aclk;

  int edge_cnt = 0;
  always @(posedge axi_aclk) edge_cnt++;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit is_grant;
    int idx;
    int edge_no;
  } ev_t;

  ev_t exp_q[$];
  int  grant_log[$];

  // Reference model state: queue that had the last turn, packets left in
  // that turn, whether a packet is in flight, sticky error.
  int m_last   = N - 1;
  int m_credit = 0;
  bit m_busy   = 1'b0;
  bit m_err    = 1'b0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  function automatic int wt(input int i);
    return int'(weights[i*W +: W]);
  endfunction

  // Predicts what the coming clock edge does with the inputs now applied.
  task automatic model_edge();
    bit [N-1:0] el;
    int         pick;
    ev_t        e;
    for (int i = 0; i < N; i++) el[i] = req[i] && (wt(i) != 0);
    if (m_busy) begin
      if (pkt_done) begin
        m_busy = 1'b0;
        e = '{is_grant: 1'b0, idx: 0, edge_no: edge_cnt + 1};
        exp_q.push_back(e);
      end
    end else begin
      if (pkt_done) m_err = 1'b1;
      if (sched_en && el != 0) begin
        if (m_credit > 0 && el[m_last]) begin
          pick = m_last;
          m_credit--;
        end else begin
          pick = -1;
          for (int k = 1; k <= N; k++) begin
            int q;
            q = (m_last + k) % N;
            if (pick < 0 && el[q]) pick = q;
          end
          m_credit = wt(pick) - 1;
        end
        m_last = pick;
        m_busy = 1'b1;
        e = '{is_grant: 1'b1, idx: pick, edge_no: edge_cnt + 1};
        exp_q.push_back(e);
      end
    end
  endtask

  // Called at a falling edge with inputs already set; returns at the next one.
  task automatic cycle(input bit done);
    pkt_done = done;
    model_edge();
    @(negedge axi_aclk);
    pkt_done = 1'b0;
  endtask

  task automatic do_reset();
    check("pending_events_at_reset", exp_q.size(), 0);
    exp_q.delete();
    axi_resetn = 1'b0;
    pkt_done   = 1'b0;
    #1;
    check("rst_grant", grant, 0);
    check("rst_grant_valid", grant_valid, 0);
    check("rst_grant_idx", grant_idx, 0);
    check("rst_pkt_fwd", pkt_fwd, 0);
    check("rst_err", err_spurious_done, 0);
    m_last = N - 1; m_credit = 0; m_busy = 1'b0; m_err = 1'b0;
    @(negedge axi_aclk);
    @(negedge axi_aclk);
    axi_resetn = 1'b1;
    grant_log.delete();
  endtask

  // Waits (bounded) for a predicted grant, holds it gap cycles, then completes it.
  task automatic send_pkts(input int n, input int gap);
    for (int p = 0; p < n; p++) begin
      int guard;
      guard = 0;
      while (!m_busy && guard < 40) begin
        cycle(1'b0);
        guard++;
      end
      if (!m_busy) break;
      repeat (gap) cycle(1'b0);
      cycle(1'b1);
    end
  endtask

  task automatic check_seq(input string name, input int exp_seq[$]);
    check({name, "_len"}, grant_log.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size() && i < grant_log.size(); i++)
      check($sformatf("%s[%0d]", name, i), grant_log[i], exp_seq[i]);
  endtask

  task automatic rand_inputs();
    req      = N'($urandom);
    sched_en = ($urandom_range(0, 7) != 0);
    for (int i = 0; i < N; i++)
      weights[i*W +: W] = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 15))
                                                      : W'($urandom_range(0, 3));
  endtask

  // Monitor: compares every observed grant start / packet-forward pulse
  // against the next predicted event, and checks grant invariants each cycle.
  initial begin
    bit  prev_v;
    int  prev_idx;
    ev_t e;
    prev_v   = 1'b0;
    prev_idx = 0;
    forever begin
      @(posedge axi_aclk);
      #1;
      if (!axi_resetn) begin
        prev_v = 1'b0;
        continue;
      end
      check("grant_valid_vs_grant", grant_valid, |grant);
      check("grant_onehot_vs_idx", grant, grant_valid ? (1 << grant_idx) : 0);
      if (prev_v && grant_valid) check("grant_held", grant_idx, prev_idx);
      if (pkt_fwd) begin
        check("fwd_was_predicted", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("fwd_event_kind", e.is_grant, 0);
          check("fwd_edge", edge_cnt, e.edge_no);
        end
      end
      if (grant_valid && !prev_v) begin
        grant_log.push_back(int'(grant_idx));
        check("grant_was_predicted", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("grant_event_kind", e.is_grant, 1);
          check("grant_idx", grant_idx, e.idx);
          check("grant_edge", edge_cnt, e.edge_no);
        end
      end
      prev_v   = grant_valid;
      prev_idx = int'(grant_idx);
    end
  end

  initial begin
    int seq[$];
    @(negedge axi_aclk);
    do_reset();

    // Single queue, single packet.
    weights = {N{4'd1}};
    sched_en = 1'b1;
    req = 5'b00001;
    cycle(1'b0);
    check("t1_grant_valid", grant_valid, 1);
    check("t1_grant", grant, 5'b00001);
    check("t1_grant_idx", grant_idx, 0);
    req = '0;
    cycle(1'b1);
    check("t1_pkt_fwd", pkt_fwd, 1);
    check("t1_grant_cleared", grant, 0);
    cycle(1'b0);
    check("t1_pkt_fwd_single", pkt_fwd, 0);

    // All queues, weight 1: plain rotation.
    do_reset();
    weights = {N{4'd1}};
    req = 5'b11111;
    send_pkts(6, 1);
    req = '0;
    repeat (3) cycle(1'b0);
    seq = '{0, 1, 2, 3, 4, 0};
    check_seq("t2_rotation", seq);

    // Weighted: queue 0 gets three packets per turn.
    do_reset();
    weights = {N{4'd1}};
    weights[0*W +: W] = 4'd3;
    req = 5'b00011;
    send_pkts(8, 0);
    req = '0;
    repeat (3) cycle(1'b0);
    seq = '{0, 0, 0, 1, 0, 0, 0, 1};
    check_seq("t3_weighted", seq);

    // Weight 0 disables queue 2.
    do_reset();
    weights = {N{4'd1}};
    weights[2*W +: W] = 4'd0;
    req = 5'b10101;
    send_pkts(4, 2);
    req = '0;
    repeat (3) cycle(1'b0);
    seq = '{0, 4, 0, 4};
    check_seq("t4_disabled", seq);

    // Input changes during a transfer do not disturb the held grant.
    do_reset();
    weights = {N{4'd1}};
    req = 5'b00110;
    cycle(1'b0);
    check("t5_first_idx", grant_idx, 1);
    req = 5'b00100;
    sched_en = 1'b0;
    weights[1*W +: W] = 4'd7;
    repeat (3) cycle(1'b0);
    check("t5_held_valid", grant_valid, 1);
    check("t5_held_idx", grant_idx, 1);
    cycle(1'b1);
    repeat (4) cycle(1'b0);
    check("t5_no_grant_when_disabled", grant_valid, 0);
    sched_en = 1'b1;
    cycle(1'b0);
    check("t5_resume_idx", grant_idx, 2);
    req = '0;
    cycle(1'b1);
    repeat (2) cycle(1'b0);
    seq = '{1, 2};
    check_seq("t5_sequence", seq);

    // Spurious pkt_done while idle.
    cycle(1'b1);
    check("t6_err_set", err_spurious_done, 1);
    check("t6_no_fwd", pkt_fwd, 0);
    repeat (3) cycle(1'b0);
    check("t6_err_sticky", err_spurious_done, 1);

    // Reset in the middle of a transfer.
    req = 5'b00001;
    cycle(1'b0);
    check("t7_busy_before_reset", grant_valid, 1);
    do_reset();

    // Randomized traffic against the reference model.
    for (int p = 0; p < 250; p++) begin
      int guard;
      rand_inputs();
      guard = 0;
      while (!m_busy && guard < 6) begin
        cycle(1'b0);
        guard++;
        if (!m_busy && $urandom_range(0, 1) == 1) rand_inputs();
      end
      if (m_busy) begin
        int gap;
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          if ($urandom_range(0, 1) == 1) rand_inputs();
          cycle(1'b0);
        end
        cycle(1'b1);
      end
    end
    req = '0;
    repeat (4) cycle(1'b0);
    check("final_err_flag", err_spurious_done, m_err);
    check("final_no_pending_events", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
